// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: bus widths, RGB bit order, frame-memory address layout
// and the capture FSM state type.
package hub75_pkg;

   localparam int HUB75_RGB_W = 6;

   // Bit positions inside the {r1,g1,b1,r0,g0,b0} pixel word
   localparam int RGB_B0 = 0;
   localparam int RGB_G0 = 1;
   localparam int RGB_R0 = 2;
   localparam int RGB_B1 = 3;
   localparam int RGB_G1 = 4;
   localparam int RGB_R1 = 5;

   localparam int PLANE_W = 3;
   localparam int ROW_W   = 5;
   localparam int COL_W   = 6;
   localparam int ADDR_W  = 1 + PLANE_W + ROW_W + COL_W;
   localparam int DATA_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DRAIN = 2'd2
   } rx_state_t;

   function automatic logic [ADDR_W-1:0] fb_addr(
      input logic [PLANE_W-1:0] plane,
      input logic [ROW_W-1:0]   row,
      input logic [COL_W-1:0]   col
   );
      return {1'b0, plane, row, col};
   endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// Two-flop synchronizer for the HUB75 pins plus rising-edge detect on clk and latch.
// Data is taken from the same stage that produces the edge so the two stay aligned.
module hub75_rx_sync
   import hub75_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_hub_clk,
   input  logic                   i_hub_latch,
   input  logic [4:0]             i_hub_abcde,
   input  logic [HUB75_RGB_W-1:0] i_hub_rgb,
   output logic [4:0]             o_abcde,
   output logic [HUB75_RGB_W-1:0] o_rgb,
   output logic                   o_clk_rise,
   output logic                   o_latch_rise
);

   localparam int W = 2 + 5 + HUB75_RGB_W;

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   logic [1:0]   r_edge;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_edge <= '0;
      end else begin
         r_meta <= {i_hub_clk, i_hub_latch, i_hub_abcde, i_hub_rgb};
         r_sync <= r_meta;
         r_edge <= r_sync[W-1 -: 2];
      end
   end

   assign o_clk_rise   = r_sync[W-1] & ~r_edge[1];
   assign o_latch_rise = r_sync[W-2] & ~r_edge[0];
   assign o_abcde      = r_sync[HUB75_RGB_W +: 5];
   assign o_rgb        = r_sync[HUB75_RGB_W-1:0];

endmodule

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: rebuilds each latched row from the panel bus into a burst of
// frame-memory writes {plane,row,col} -> pixel.
module hub75_rx_capture
   import hub75_pkg::*;
#(
   parameter int COLS   = 64,
   parameter int ROWS   = 32,
   parameter int PLANES = 8
)
(
   input  logic                   PCLK,
   input  logic                   PRESETN,
   input  logic                   enable,
   input  logic                   clear_err,
   input  logic                   hub_clk,
   input  logic                   hub_latch,
   input  logic                   hub_oe,
   input  logic [4:0]             hub_abcde,
   input  logic [HUB75_RGB_W-1:0] hub_rgb,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   output logic                   frame_start,
   output logic                   overrun,
   output logic                   short_row
);

   localparam int CB      = $clog2(COLS);
   localparam int RB      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PB      = (PLANES > 1) ? $clog2(PLANES) : 1;
   localparam int COLS_M1 = COLS - 1;
   localparam logic [CB:0]   CNT_FULL = COLS[CB:0];
   localparam logic [CB-1:0] COL_LAST = COLS_M1[CB-1:0];

   logic [4:0]                               w_abcde;
   logic [HUB75_RGB_W-1:0]                   w_rgb;
   logic                                     w_clk_rise;
   logic                                     w_latch_rise;
   logic [RB-1:0]                            w_row;
   logic [COLS-1:0][HUB75_RGB_W-1:0]         w_line_next;
   logic [CB:0]                              w_shift_cnt_next;
   logic                                     w_unused;

   logic [COLS-1:0][HUB75_RGB_W-1:0]         r_line;
   logic [COLS-1:0][HUB75_RGB_W-1:0]         r_drain_buf;
   logic [CB:0]                              r_shift_cnt;
   logic [CB-1:0]                            r_col;
   logic [RB-1:0]                            r_row;
   logic [RB-1:0]                            r_prev_row;
   logic [PB-1:0]                            r_plane;
   rx_state_t                                r_state;
   logic                                     r_wr_en;
   logic [ADDR_W-1:0]                        r_wr_addr;
   logic [DATA_W-1:0]                        r_wr_data;
   logic                                     r_frame_start;
   logic                                     r_overrun;
   logic                                     r_short_row;

   hub75_rx_sync u_sync (
      .i_clk        (PCLK),
      .i_rst_n      (PRESETN),
      .i_hub_clk    (hub_clk),
      .i_hub_latch  (hub_latch),
      .i_hub_abcde  (hub_abcde),
      .i_hub_rgb    (hub_rgb),
      .o_abcde      (w_abcde),
      .o_rgb        (w_rgb),
      .o_clk_rise   (w_clk_rise),
      .o_latch_rise (w_latch_rise)
   );

   assign w_row    = w_abcde[RB-1:0];
   assign w_unused = ^{hub_oe, w_abcde};

   // The shift is resolved before any copy, so a coincident latch captures the new pixel
   always_comb begin
      w_line_next      = r_line;
      w_shift_cnt_next = r_shift_cnt;
      if (w_clk_rise) begin
         w_line_next = {w_rgb, r_line[COLS-1:1]};
         if (r_shift_cnt != CNT_FULL)
            w_shift_cnt_next = r_shift_cnt + (CB+1)'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         r_line        <= '0;
         r_drain_buf   <= '0;
         r_shift_cnt   <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_prev_row    <= '0;
         r_plane       <= '0;
         r_state       <= ST_IDLE;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_start <= 1'b0;
         r_overrun     <= 1'b0;
         r_short_row   <= 1'b0;
      end else begin
         r_line        <= w_line_next;
         r_shift_cnt   <= w_shift_cnt_next;
         r_wr_en       <= 1'b0;
         r_frame_start <= 1'b0;
         if (clear_err) begin
            r_overrun   <= 1'b0;
            r_short_row <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               // Arming latch is discarded; plane starts at the top so a repeat of this row lands on plane 0
               if (enable && w_latch_rise) begin
                  r_state     <= ST_ARMED;
                  r_prev_row  <= w_row;
                  r_plane     <= '1;
                  r_shift_cnt <= '0;
               end
            end
            ST_ARMED: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
               end else if (w_latch_rise) begin
                  r_drain_buf <= w_line_next;
                  r_row       <= w_row;
                  r_plane     <= (w_row == r_prev_row) ? r_plane + PB'(1) : '0;
                  r_prev_row  <= w_row;
                  if (w_shift_cnt_next < CNT_FULL)
                     r_short_row <= 1'b1;
                  r_shift_cnt <= '0;
                  r_col       <= '0;
                  r_state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_wr_en       <= 1'b1;
               r_wr_addr     <= fb_addr(PLANE_W'(r_plane), ROW_W'(r_row), COL_W'(r_col));
               r_wr_data     <= DATA_W'(r_drain_buf[r_col]);
               r_frame_start <= (r_col == '0) && (r_plane == '0) && (r_row == '0);
               if (w_latch_rise)
                  r_overrun <= 1'b1;
               if (r_col == COL_LAST)
                  r_state <= enable ? ST_ARMED : ST_IDLE;
               else
                  r_col <= r_col + CB'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign frame_start = r_frame_start;
   assign overrun     = r_overrun;
   assign short_row   = r_short_row;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Bench for hub75_rx_capture: drives HUB75 rows from a table, scoreboards every write,
// plus hand sequences for overrun, enable drop and reset mid-drain.
`timescale 1ns/1ps
module tb_hub75_rx_capture;

   logic        PCLK = 1'b0;
   logic        PRESETN = 1'b0;
   logic        enable = 1'b0;
   logic        clear_err = 1'b0;
   logic        hub_clk = 1'b0;
   logic        hub_latch = 1'b0;
   logic        hub_oe = 1'b0;
   logic [4:0]  hub_abcde = '0;
   logic [5:0]  hub_rgb = '0;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [31:0] wr_data;
   logic        frame_start;
   logic        overrun;
   logic        short_row;

   hub75_rx_capture #(.COLS(64), .ROWS(32), .PLANES(8)) dut (
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .enable      (enable),
      .clear_err   (clear_err),
      .hub_clk     (hub_clk),
      .hub_latch   (hub_latch),
      .hub_oe      (hub_oe),
      .hub_abcde   (hub_abcde),
      .hub_rgb     (hub_rgb),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_start (frame_start),
      .overrun     (overrun),
      .short_row   (short_row)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic [14:0] addr;
      logic [31:0] data;
      logic        fs;
   } wr_t;

   typedef struct {
      logic [4:0] row;
      int         nsh;
      bit         rnd;
      int         plane;
      bit         short_exp;
   } vec_t;

   wr_t        exp_q[$];
   logic [5:0] mline[64];
   vec_t       tbl[8];
   int         n_pass = 0;
   int         n_total = 0;
   int         wr_cnt = 0;
   int         cyc = 0;
   int         first_wr_cyc = -1;

   function automatic void chk(input bit ok, input string name,
                               input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   initial forever begin
      @(posedge PCLK);
      cyc++;
   end

   // Write monitor: one scoreboard comparison per observed write
   initial begin
      wr_t got;
      wr_t e;
      bit  have;
      forever begin
         @(negedge PCLK);
         if (wr_en === 1'b1) begin
            got = {wr_addr, wr_data, frame_start};
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            have = (exp_q.size() != 0);
            e = '0;
            if (have) e = exp_q.pop_front();
            chk(have && (got == e), have ? "write" : "unexpected_write", 64'(got), 64'(e));
            $display("wr #%0d addr=0x%04h data=0x%02h fs=%0b", wr_cnt, wr_addr, wr_data, frame_start);
         end else begin
            chk(frame_start === 1'b0, "fs_without_write", 64'(frame_start), 64'(0));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic shift_px(input logic [5:0] px);
      @(negedge PCLK); hub_rgb = px; hub_clk = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK); hub_clk = 1'b1;
      @(negedge PCLK);
      for (int c = 0; c < 63; c++) mline[c] = mline[c+1];
      mline[63] = px;
   endtask

   task automatic shift_n(input int n, input bit rnd);
      logic [5:0] px;
      for (int i = 0; i < n; i++) begin
         px = rnd ? 6'($urandom_range(0, 63)) : 6'(i);
         shift_px(px);
      end
   endtask

   task automatic push_row(input logic [4:0] row, input int plane);
      wr_t w;
      for (int c = 0; c < 64; c++) begin
         w.addr = {1'b0, 3'(plane), row, 6'(c)};
         w.data = {26'b0, mline[c]};
         w.fs   = (plane == 0) && (row == 5'd0) && (c == 0);
         exp_q.push_back(w);
      end
   endtask

   task automatic latch_px(input logic [4:0] row, output int lc);
      @(negedge PCLK); hub_abcde = row; hub_clk = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK); hub_latch = 1'b1; lc = cyc; first_wr_cyc = -1;
      @(negedge PCLK);
      @(negedge PCLK); hub_latch = 1'b0;
   endtask

   task automatic wait_writes(input int target, input int bound);
      for (int k = 0; k < bound && wr_cnt < target; k++) begin
         @(negedge PCLK); #1;
      end
   endtask

   task automatic pulse_clear();
      @(negedge PCLK); clear_err = 1'b1;
      @(negedge PCLK); clear_err = 1'b0;
      @(negedge PCLK);
   endtask

   task automatic do_row(input vec_t v, input bit expect_wr);
      int base;
      int lc;
      shift_n(v.nsh, v.rnd);
      if (expect_wr) push_row(v.row, v.plane);
      base = wr_cnt;
      latch_px(v.row, lc);
      if (expect_wr) wait_writes(base + 64, 200);
      else           wait_writes(base + 1, 80);
      $display("row=%0d shifts=%0d writes=%0d short_row=%0b", v.row, v.nsh, wr_cnt - base, short_row);
      chk(wr_cnt - base == (expect_wr ? 64 : 0), "row_writes", 64'(wr_cnt - base), 64'(expect_wr ? 64 : 0));
      if (expect_wr)
         chk(first_wr_cyc - lc == 4, "latency", 64'(first_wr_cyc - lc), 64'(4));
      chk(short_row == v.short_exp, "short_row", 64'(short_row), 64'(v.short_exp));
      if (v.short_exp) begin
         pulse_clear();
         chk(short_row == 1'b0, "short_row_clear", 64'(short_row), 64'(0));
      end
   endtask

   initial begin
      vec_t v;
      int   base;
      int   lc;
      int   lc2;

      for (int c = 0; c < 64; c++) mline[c] = '0;
      tbl[0] = '{5'd0, 64, 1'b0, 0, 1'b0};
      tbl[1] = '{5'd5, 64, 1'b1, 0, 1'b0};
      tbl[2] = '{5'd5, 64, 1'b1, 1, 1'b0};
      tbl[3] = '{5'd5, 64, 1'b1, 2, 1'b0};
      tbl[4] = '{5'd5, 64, 1'b1, 3, 1'b0};
      tbl[5] = '{5'd6, 64, 1'b1, 0, 1'b0};
      tbl[6] = '{5'd6, 70, 1'b0, 1, 1'b0};
      tbl[7] = '{5'd3, 40, 1'b1, 0, 1'b1};

      repeat (3) @(negedge PCLK);
      chk(wr_en == 1'b0, "reset_wr_en_async", 64'(wr_en), 64'(0));
      PRESETN = 1'b1;
      enable  = 1'b1;
      @(negedge PCLK);
      chk(wr_en == 1'b0,       "reset_wr_en",       64'(wr_en),       64'(0));
      chk(wr_addr == '0,       "reset_wr_addr",     64'(wr_addr),     64'(0));
      chk(wr_data == '0,       "reset_wr_data",     64'(wr_data),     64'(0));
      chk(frame_start == 1'b0, "reset_frame_start", 64'(frame_start), 64'(0));
      chk(overrun == 1'b0,     "reset_overrun",     64'(overrun),     64'(0));
      chk(short_row == 1'b0,   "reset_short_row",   64'(short_row),   64'(0));

      // Arming latch on row 0: nothing written
      v = '{5'd0, 0, 1'b0, 0, 1'b0};
      do_row(v, 1'b0);

      for (int i = 0; i < 8; i++) do_row(tbl[i], 1'b1);

      // Overrun: second latch lands mid-drain and is ignored
      shift_n(64, 1'b1);
      push_row(5'd7, 0);
      base = wr_cnt;
      latch_px(5'd7, lc);
      repeat (12) @(negedge PCLK);
      latch_px(5'd7, lc2);
      wait_writes(base + 64, 200);
      repeat (40) @(negedge PCLK);
      $display("overrun sequence: writes=%0d overrun=%0b", wr_cnt - base, overrun);
      chk(wr_cnt - base == 64, "overrun_writes", 64'(wr_cnt - base), 64'(64));
      chk(overrun == 1'b1, "overrun_set", 64'(overrun), 64'(1));
      pulse_clear();
      chk(overrun == 1'b0, "overrun_clear", 64'(overrun), 64'(0));
      v = '{5'd7, 64, 1'b1, 1, 1'b0};
      do_row(v, 1'b1);

      // Enable drops mid-drain: the drain completes, then IDLE writes nothing
      shift_n(64, 1'b1);
      push_row(5'd2, 0);
      base = wr_cnt;
      latch_px(5'd2, lc);
      repeat (20) @(negedge PCLK);
      enable = 1'b0;
      wait_writes(base + 64, 200);
      $display("enable drop: writes=%0d", wr_cnt - base);
      chk(wr_cnt - base == 64, "en_off_writes", 64'(wr_cnt - base), 64'(64));
      v = '{5'd2, 10, 1'b1, 0, 1'b0};
      do_row(v, 1'b0);
      enable = 1'b1;
      v = '{5'd4, 0, 1'b0, 0, 1'b0};
      do_row(v, 1'b0);

      // Reset at write 20 of a drain
      shift_n(64, 1'b1);
      push_row(5'd4, 0);
      base = wr_cnt;
      latch_px(5'd4, lc);
      for (int k = 0; k < 200 && wr_cnt < base + 20; k++) begin
         @(negedge PCLK); #1;
      end
      PRESETN = 1'b0;
      #1;
      $display("reset mid-drain after %0d writes, wr_en=%0b", wr_cnt - base, wr_en);
      chk(wr_en == 1'b0, "rst_wr_en", 64'(wr_en), 64'(0));
      chk(wr_cnt - base == 20, "rst_at_write", 64'(wr_cnt - base), 64'(20));
      exp_q.delete();
      for (int c = 0; c < 64; c++) mline[c] = '0;
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);
      chk(wr_en == 1'b0, "post_rst_wr_en", 64'(wr_en), 64'(0));
      v = '{5'd4, 64, 1'b1, 0, 1'b0};
      do_row(v, 1'b0);
      v = '{5'd0, 64, 1'b0, 0, 1'b0};
      do_row(v, 1'b1);

      repeat (10) @(negedge PCLK);
      chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
